// File: rtl/riscv_core_if_fetch_ctrl.sv
// Fetch-control front end of the IF stage.
// It issues instruction-bus requests for the current PC. It buffers a response
// that ID cannot take yet, and it handles ID stalls and branch redirects.
// Ports:
//   CLK, RST                      clock, synchronous active-low reset
//   ACT                           stage activity (IF output unit write enable)
//   r_pc_Q                        current PC register value
//   redirect_valid, redirect_pc   one-cycle redirect request and target
//   id_stall_req                  ID cannot accept an instruction this cycle
//   ibus_req, ibus_addr           registered instruction bus request
//   ibus_ack, ibus_rdata, ibus_err  bus response
//   s_if_pcin_Q                   next PC (combinational)
//   s_id_clear_Q, s_id_stall_Q    ID bubble / hold controls (combinational)
//   if_instr, if_fault            registered instruction for ID and its fault flag
module riscv_core_if_fetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ACT,
  input  logic [31:0] r_pc_Q,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        id_stall_req,
  output logic        ibus_req,
  output logic [31:0] ibus_addr,
  input  logic        ibus_ack,
  input  logic [31:0] ibus_rdata,
  input  logic        ibus_err,
  output logic [31:0] s_if_pcin_Q,
  output logic        s_id_clear_Q,
  output logic        s_id_stall_Q,
  output logic [31:0] if_instr,
  output logic        if_fault
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {IDLE, WAIT_ACK, HOLD, FLUSH} state_t;

  state_t            state, state_d;
  logic              req_d;
  logic [XLEN-1:0]   addr_d;
  logic [XLEN-1:0]   hold_data, hold_data_d;
  logic              hold_err, hold_err_d;
  logic [XLEN-1:0]   instr_d;
  logic              fault_d;

  logic              deliver;
  logic [XLEN-1:0]   pc_plus4;
  logic [XLEN-1:0]   dlv_data;
  logic              dlv_err;
  logic              unused_bits;

  // Only the word address of a redirect target matters.
  assign unused_bits = ^redirect_pc[1:0];

  assign pc_plus4 = r_pc_Q + XLEN'(4);

  // An instruction is handed to ID only when ID can take it and no redirect is pending.
  assign deliver = ACT & ~id_stall_req & ~redirect_valid &
                   (((state == WAIT_ACK) & ibus_ack) | (state == HOLD));

  assign dlv_data = (state == HOLD) ? hold_data : ibus_rdata;
  assign dlv_err  = (state == HOLD) ? hold_err  : ibus_err;

  // Next-PC selection: redirect, then sequential advance, else hold.
  always_comb begin
    s_if_pcin_Q = r_pc_Q;
    if (redirect_valid) begin
      s_if_pcin_Q = {redirect_pc[XLEN-1:2], 2'b00};
    end else if (deliver) begin
      s_if_pcin_Q = pc_plus4;
    end
  end

  assign s_id_clear_Q = redirect_valid | ~deliver;
  assign s_id_stall_Q = id_stall_req & ~redirect_valid;

  // Next-state, bus request and hold-buffer logic.
  always_comb begin
    state_d     = state;
    req_d       = ibus_req;
    addr_d      = ibus_addr;
    hold_data_d = hold_data;
    hold_err_d  = hold_err;
    unique case (state)
      IDLE: begin
        if (ACT && !redirect_valid) begin
          req_d   = 1'b1;
          addr_d  = {r_pc_Q[XLEN-1:2], 2'b00};
          state_d = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (ibus_ack) begin
          if (redirect_valid) begin
            req_d   = 1'b0;
            state_d = IDLE;
          end else if (deliver) begin
            // Back-to-back issue keeps one instruction per ack.
            addr_d = {pc_plus4[XLEN-1:2], 2'b00};
          end else begin
            req_d       = 1'b0;
            hold_data_d = ibus_rdata;
            hold_err_d  = ibus_err;
            state_d     = HOLD;
          end
        end else if (redirect_valid) begin
          // The request cannot be withdrawn; wait out its ack and drop it.
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (ibus_ack) begin
          req_d   = 1'b0;
          state_d = IDLE;
        end
      end
      HOLD: begin
        if (deliver) begin
          state_d = IDLE;
        end else if (redirect_valid) begin
          hold_data_d = '0;
          hold_err_d  = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Instruction register handed to ID alongside r_id_pc.
  always_comb begin
    instr_d = if_instr;
    fault_d = if_fault;
    if (ACT) begin
      if (deliver) begin
        instr_d = dlv_err ? NOP_INSTR : dlv_data;
        fault_d = dlv_err;
      end else if (!s_id_stall_Q) begin
        instr_d = NOP_INSTR;
        fault_d = 1'b0;
      end
    end
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state     <= IDLE;
      ibus_req  <= 1'b0;
      ibus_addr <= RESET_PC;
      hold_data <= '0;
      hold_err  <= 1'b0;
      if_instr  <= NOP_INSTR;
      if_fault  <= 1'b0;
    end else begin
      state     <= state_d;
      ibus_req  <= req_d;
      ibus_addr <= addr_d;
      hold_data <= hold_data_d;
      hold_err  <= hold_err_d;
      if_instr  <= instr_d;
      if_fault  <= fault_d;
    end
  end

endmodule

// File: tb/tb_riscv_core_if_fetch_ctrl.sv
// Bench for riscv_core_if_fetch_ctrl: a directed vector table followed by
// random stimulus checked against a transaction-level reference model.
module tb_riscv_core_if_fetch_ctrl;

  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] RSTPC = 32'h0000_0000;

  logic        CLK = 1'b0;
  logic        RST, ACT, redirect_valid, id_stall_req;
  logic [31:0] r_pc_Q, redirect_pc;
  logic        ibus_req, ibus_ack, ibus_err;
  logic [31:0] ibus_addr, ibus_rdata;
  logic [31:0] s_if_pcin_Q;
  logic        s_id_clear_Q, s_id_stall_Q;
  logic [31:0] if_instr;
  logic        if_fault;

  riscv_core_if_fetch_ctrl dut (
    .CLK(CLK), .RST(RST), .ACT(ACT), .r_pc_Q(r_pc_Q),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_stall_req(id_stall_req),
    .ibus_req(ibus_req), .ibus_addr(ibus_addr),
    .ibus_ack(ibus_ack), .ibus_rdata(ibus_rdata), .ibus_err(ibus_err),
    .s_if_pcin_Q(s_if_pcin_Q), .s_id_clear_Q(s_id_clear_Q),
    .s_id_stall_Q(s_id_stall_Q), .if_instr(if_instr), .if_fault(if_fault)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        rst, act, stall, redir, ack, err, set_rpc;
    logic [31:0] rpc_val, rpc_redir, rdata;
    logic        e_req;
    logic [31:0] e_addr, e_pcin;
    logic        e_clear, e_stall;
    logic [31:0] e_instr;
    logic        e_fault;
  } vec_t;

  int checks = 0;
  int errors = 0;

  // Reference model: transaction view of the fetch unit.
  logic        m_out  = 1'b0;   // a request is outstanding on the bus
  logic        m_disc = 1'b0;   // its response must be thrown away
  logic        m_buf  = 1'b0;   // a fetched word is parked for ID
  logic [31:0] m_bdata = '0;
  logic        m_berr  = 1'b0;
  logic [31:0] m_addr  = RSTPC;
  logic [31:0] m_instr = NOP;
  logic        m_fault = 1'b0;
  logic [31:0] rpc     = RSTPC;  // IF output unit's r_pc

  function automatic vec_t r(input logic act, stall, redir, input logic [31:0] rpcr,
                             input logic ack, input logic [31:0] rd, input logic err,
                             input logic e_req, input logic [31:0] e_addr, e_pcin,
                             input logic e_clear, e_stall, input logic [31:0] e_instr,
                             input logic e_fault);
    vec_t v;
    v.rst = 1'b1; v.act = act; v.stall = stall; v.redir = redir; v.rpc_redir = rpcr;
    v.ack = ack; v.rdata = rd; v.err = err; v.set_rpc = 1'b0; v.rpc_val = '0;
    v.e_req = e_req; v.e_addr = e_addr; v.e_pcin = e_pcin; v.e_clear = e_clear;
    v.e_stall = e_stall; v.e_instr = e_instr; v.e_fault = e_fault;
    return v;
  endfunction

  task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
    end
  endtask

  // One clock cycle: drive, sample at negedge, advance model at posedge.
  task automatic step(input vec_t v, input bit use_tab, input bit chk);
    logic        dlv, x_stall, x_clear;
    logic [31:0] x_pcin, d_data;
    logic        d_err;
    if (v.set_rpc) rpc = v.rpc_val;
    RST = v.rst; ACT = v.act; id_stall_req = v.stall; redirect_valid = v.redir;
    redirect_pc = v.rpc_redir; ibus_ack = v.ack; ibus_rdata = v.rdata;
    ibus_err = v.err; r_pc_Q = rpc;
    @(negedge CLK);
    dlv     = v.act && !v.stall && !v.redir && ((m_out && !m_disc && v.ack) || m_buf);
    d_data  = m_buf ? m_bdata : v.rdata;
    d_err   = m_buf ? m_berr  : v.err;
    x_pcin  = v.redir ? {v.rpc_redir[31:2], 2'b00} : (dlv ? rpc + 32'd4 : rpc);
    x_clear = v.redir || !dlv;
    x_stall = v.stall && !v.redir;
    if (chk) begin
      cmp("ibus_req",     32'(ibus_req),     use_tab ? 32'(v.e_req)   : 32'(m_out));
      cmp("ibus_addr",    ibus_addr,         use_tab ? v.e_addr       : m_addr);
      cmp("s_if_pcin_Q",  s_if_pcin_Q,       use_tab ? v.e_pcin       : x_pcin);
      cmp("s_id_clear_Q", 32'(s_id_clear_Q), use_tab ? 32'(v.e_clear) : 32'(x_clear));
      cmp("s_id_stall_Q", 32'(s_id_stall_Q), use_tab ? 32'(v.e_stall) : 32'(x_stall));
      cmp("if_instr",     if_instr,          use_tab ? v.e_instr      : m_instr);
      cmp("if_fault",     32'(if_fault),     use_tab ? 32'(v.e_fault) : 32'(m_fault));
    end
    @(posedge CLK);
    if (!v.rst) begin
      m_out = 1'b0; m_disc = 1'b0; m_buf = 1'b0; m_bdata = '0; m_berr = 1'b0;
      m_addr = RSTPC; m_instr = NOP; m_fault = 1'b0;
    end else begin
      if (v.act) begin
        if (dlv) begin
          m_instr = d_err ? NOP : d_data;
          m_fault = d_err;
        end else if (!x_stall) begin
          m_instr = NOP;
          m_fault = 1'b0;
        end
      end
      if (m_out) begin
        if (v.ack) begin
          if (m_disc || v.redir) begin
            m_out = 1'b0; m_disc = 1'b0;
          end else if (dlv) begin
            m_addr = (rpc + 32'd4) & 32'hFFFF_FFFC;
          end else begin
            m_out = 1'b0; m_buf = 1'b1; m_bdata = v.rdata; m_berr = v.err;
          end
        end else if (v.redir) begin
          m_disc = 1'b1;
        end
      end else if (m_buf) begin
        if (dlv || v.redir) m_buf = 1'b0;
      end else if (v.act && !v.redir) begin
        m_out  = 1'b1;
        m_addr = rpc & 32'hFFFF_FFFC;
      end
      if (v.act) rpc = x_pcin;
    end
    #1;
  endtask

  vec_t tab[35];
  vec_t rv;

  initial begin
    tab[0]  = r(1,0,0,0, 0,0,0,            0,32'h0,  32'h0,  1,0,NOP,0);
    tab[1]  = r(1,0,0,0, 0,0,0,            1,32'h0,  32'h0,  1,0,NOP,0);
    tab[2]  = r(1,0,0,0, 1,32'hA0,0,       1,32'h0,  32'h4,  0,0,NOP,0);
    tab[3]  = r(1,0,0,0, 0,0,0,            1,32'h4,  32'h4,  1,0,32'hA0,0);
    tab[4]  = r(1,0,0,0, 1,32'hA1,0,       1,32'h4,  32'h8,  0,0,NOP,0);
    tab[5]  = r(1,0,0,0, 0,0,0,            1,32'h8,  32'h8,  1,0,32'hA1,0);
    tab[6]  = r(1,0,0,0, 1,32'hA2,0,       1,32'h8,  32'hC,  0,0,NOP,0);
    tab[7]  = r(1,0,0,0, 0,0,0,            1,32'hC,  32'hC,  1,0,32'hA2,0);
    tab[8]  = r(1,0,0,0, 1,32'hA3,0,       1,32'hC,  32'h10, 0,0,NOP,0);
    tab[9]  = r(1,1,0,0, 0,0,0,            1,32'h10, 32'h10, 1,1,32'hA3,0);
    tab[10] = r(1,1,0,0, 1,32'hB0,0,       1,32'h10, 32'h10, 1,1,32'hA3,0);
    tab[11] = r(1,1,0,0, 0,0,0,            0,32'h10, 32'h10, 1,1,32'hA3,0);
    tab[12] = r(1,0,0,0, 0,0,0,            0,32'h10, 32'h14, 0,0,32'hA3,0);
    tab[13] = r(1,0,0,0, 0,0,0,            0,32'h10, 32'h14, 1,0,32'hB0,0);
    tab[14] = r(1,0,0,0, 1,32'hD0,0,       1,32'h14, 32'h18, 0,0,NOP,0);
    tab[15] = r(1,0,0,0, 1,32'hD1,0,       1,32'h18, 32'h1C, 0,0,32'hD0,0);
    tab[16] = r(1,0,0,0, 1,32'hD2,0,       1,32'h1C, 32'h20, 0,0,32'hD1,0);
    tab[17] = r(1,0,1,32'h203, 0,0,0,      1,32'h20, 32'h200,1,0,32'hD2,0);
    tab[18] = r(1,0,0,0, 0,0,0,            1,32'h20, 32'h200,1,0,NOP,0);
    tab[19] = r(1,0,0,0, 1,32'hC0,0,       1,32'h20, 32'h200,1,0,NOP,0);
    tab[20] = r(1,0,0,0, 0,0,0,            0,32'h20, 32'h200,1,0,NOP,0);
    tab[21] = r(1,0,1,32'h300, 1,32'hE0,0, 1,32'h200,32'h300,1,0,NOP,0);
    tab[22] = r(1,0,0,0, 0,0,0,            0,32'h200,32'h300,1,0,NOP,0);
    tab[23] = r(1,0,1,32'h40, 0,0,0,       1,32'h300,32'h40, 1,0,NOP,0);
    tab[24] = r(1,0,0,0, 1,32'hF0,0,       1,32'h300,32'h40, 1,0,NOP,0);
    tab[25] = r(1,0,0,0, 0,0,0,            0,32'h300,32'h40, 1,0,NOP,0);
    tab[26] = r(1,0,0,0, 1,32'h12345678,1, 1,32'h40, 32'h44, 0,0,NOP,0);
    tab[27] = r(1,0,0,0, 0,0,0,            1,32'h44, 32'h44, 1,0,NOP,1);
    tab[28] = r(0,0,0,0, 1,32'h55,0,       1,32'h44, 32'h44, 1,0,NOP,0);
    tab[29] = r(1,0,0,0, 0,0,0,            0,32'h44, 32'h48, 0,0,NOP,0);
    tab[30] = r(1,0,0,0, 0,0,0,            0,32'h44, 32'h48, 1,0,32'h55,0);
    tab[31] = r(1,0,0,0, 0,0,0,            1,32'h48, 32'hFFFF_FFFC,1,0,NOP,0);
    tab[31].rst = 1'b0; tab[31].set_rpc = 1'b1; tab[31].rpc_val = 32'hFFFF_FFFC;
    tab[32] = r(1,0,0,0, 0,0,0,            0,32'h0,  32'hFFFF_FFFC,1,0,NOP,0);
    tab[33] = r(1,0,0,0, 1,32'h77,0,       1,32'hFFFF_FFFC,32'h0,0,0,NOP,0);
    tab[34] = r(1,0,0,0, 0,0,0,            1,32'h0,  32'h0,  1,0,32'h77,0);

    @(posedge CLK);
    #1;
    rv = r(0,0,0,0, 0,0,0, 0,0,0,0,0,NOP,0);
    rv.rst = 1'b0;
    step(rv, 1'b0, 1'b0);
    step(rv, 1'b0, 1'b0);

    foreach (tab[i]) step(tab[i], 1'b1, 1'b1);

    for (int n = 0; n < 3000; n++) begin
      rv.rst       = ($urandom_range(99) != 0);
      rv.act       = ($urandom_range(9) != 0);
      rv.stall     = ($urandom_range(4) == 0);
      rv.redir     = ($urandom_range(9) == 0);
      rv.rpc_redir = $urandom;
      rv.ack       = m_out && ($urandom_range(1) == 1);
      rv.rdata     = $urandom;
      rv.err       = ($urandom_range(9) == 0);
      rv.set_rpc   = 1'b0;
      step(rv, 1'b0, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/riscv_core_if_fetch_ctrl.md
Name: riscv_core_if_fetch_ctrl

Overview:
- Fetch-control front end of the IF stage. Issues instruction-bus requests for the current PC, buffers the response, and handles ID stalls and branch redirects.
- Produces the IF stage signals s_if_pcin_Q, s_id_clear_Q and s_id_stall_Q, which the IF output unit registers into r_pc, r_id_clear and r_id_stall.
- Sits directly upstream of the IF output unit. Also supplies the fetched instruction word that ID consumes alongside r_id_pc.

Parameters:
- RESET_PC, 32'h00000000, fetch address used after reset. It must match the r_pc reset value.
- NOP_INSTR, 32'h00000013, instruction word delivered for bubbles and faults (addi x0,x0,0).

Ports:
- CLK  in  1  clock. Single clock domain.
- RST  in  1  synchronous reset, active-low.
- ACT  in  1  stage activity. The IF output unit writes its registers only when ACT=1.
- r_pc_Q  in  32  current PC register value.
- redirect_valid  in  1  branch/jump/exception redirect request, one cycle.
- redirect_pc  in  32  redirect target. Bits [1:0] are ignored and forced to 0.
- id_stall_req  in  1  ID hazard: ID cannot accept a new instruction this cycle.
- ibus_req  out  1  instruction bus request.
- ibus_addr  out  32  instruction bus address, word aligned.
- ibus_ack  in  1  response valid, one cycle.
- ibus_rdata  in  32  response data.
- ibus_err  in  1  response error, qualified by ibus_ack.
- s_if_pcin_Q  out  32  next PC value (combinational).
- s_id_clear_Q  out  1  insert bubble into ID (combinational).
- s_id_stall_Q  out  1  hold ID (combinational).
- if_instr  out  32  instruction paired with r_id_pc (registered).
- if_fault  out  1  fetch bus error for if_instr (registered).

Behaviour:
- Reset (RST=0 at a CLK edge):
  - state=IDLE, ibus_req=0, ibus_addr=RESET_PC.
  - hold buffer cleared, if_instr=NOP_INSTR, if_fault=0.
  - Reset mid-transaction abandons the outstanding request. The bus is reset by the same RST.
- State machine states: IDLE, WAIT_ACK, HOLD, FLUSH. All state is registered.
- Bus protocol:
  - ibus_req and ibus_addr are registered and stay stable from issue until the ibus_ack cycle.
  - A request is never withdrawn before its ack.
  - At most one request is outstanding.
- deliver is a combinational signal. It is 1 when ACT=1, id_stall_req=0, redirect_valid=0, and either:
  - state=WAIT_ACK and ibus_ack=1, or
  - state=HOLD.
- Delivered data is ibus_rdata (WAIT_ACK) or the hold buffer (HOLD).
- IDLE:
  - ibus_req=0.
  - If ACT=1 and redirect_valid=0: issue ibus_addr={r_pc_Q[31:2],2'b00} and go to WAIT_ACK.
  - Otherwise stay in IDLE.
- WAIT_ACK:
  - ack with redirect_valid=1: drop the response and go to IDLE.
  - ack with deliver=1: stay in WAIT_ACK and reissue at r_pc_Q+4. Sustained throughput is one instruction per ack.
  - ack with ACT=0 or id_stall_req=1: store {rdata, err} in the hold buffer and go to HOLD. ibus_req drops.
  - no ack and redirect_valid=1: go to FLUSH.
- FLUSH:
  - ibus_req held. On ack, discard the response and go to IDLE.
  - Further redirects while in FLUSH are absorbed by r_pc. Stay in FLUSH until the ack.
- HOLD:
  - ibus_req=0.
  - deliver=1: go to IDLE. IDLE reissues from the updated r_pc next cycle (1-cycle penalty).
  - redirect_valid=1: clear the hold buffer and go to IDLE.
- s_if_pcin_Q priority:
  1. redirect_valid=1 → {redirect_pc[31:2],2'b00}.
  2. deliver=1 → r_pc_Q+32'd4. 32-bit wrap: 0xFFFFFFFC → 0x00000000.
  3. otherwise → r_pc_Q.
- s_id_clear_Q = redirect_valid | ~deliver. ID receives a bubble whenever no instruction is handed over.
- s_id_stall_Q = id_stall_req & ~redirect_valid. A redirect overrides a stall.
- if_instr / if_fault update on each CLK edge with ACT=1:
  - deliver=1: take the delivered data. On err=1, if_instr=NOP_INSTR and if_fault=1.
  - s_id_stall_Q=1: hold the current values.
  - otherwise: if_instr=NOP_INSTR, if_fault=0.
- ACT=0 freezes if_instr and if_fault.
- The bus side keeps running while ACT=0. A response arriving then goes to HOLD.
- Simultaneous ack and redirect in the same cycle: the redirect wins and the response is discarded.

Test Plan:
1. Reset release, ACT=1, ack every 2nd cycle from 0x0 with words 0xA0,0xA1,0xA2 → ibus_addr 0x0,0x4,0x8. s_if_pcin_Q=0x4,0x8,0xC on ack cycles. if_instr=0xA0,0xA1,0xA2 and s_id_clear_Q=0 on delivery cycles only.
2. id_stall_req=1 for 3 cycles spanning an ack of 0xB0 at addr 0x10 → HOLD and ibus_req=0. s_if_pcin_Q=0x10 and s_id_stall_Q=1 during the stall. On release, if_instr=0xB0 and s_if_pcin_Q=0x14.
3. redirect_valid=1, redirect_pc=0x203 while WAIT_ACK at 0x20 with no ack → s_if_pcin_Q=0x200, s_id_clear_Q=1. FLUSH until ack, 0xC0 discarded. Next request addr=0x200.
4. ibus_ack and redirect_valid in the same cycle (target 0x300) → data not delivered, if_instr=NOP_INSTR, next ibus_addr=0x300.
5. ibus_err=1 on ack for addr 0x40 → if_instr=0x00000013, if_fault=1, s_if_pcin_Q=0x44.
6. RST=0 asserted mid-WAIT_ACK, r_pc_Q=0xFFFFFFFC; then release and deliver → all outputs return to their reset values. After release, first address 0xFFFFFFFC; on delivery s_if_pcin_Q=0x00000000.
